// File: rtl/spi_xfer_pkg.sv
// spi_xfer_pkg: shared types and constants for the SPI transfer sequencer.
//   - state_e        : sequencer FSM states
//   - ADDR_*         : SPI core register byte addresses
//   - CTRL_*_BIT     : CTRL register bit positions
//   - ctrl_word()    : builds the CTRL value written to start a character
package spi_xfer_pkg;

  typedef enum logic [3:0] {
    ST_CFG_DIV,
    ST_CFG_SS,
    ST_IDLE,
    ST_LOAD,
    ST_GO,
    ST_POLL_RD,
    ST_POLL_CK,
    ST_WAIT,
    ST_RX_RD,
    ST_RX_CAP,
    ST_RX_PUSH
  } state_e;

  localparam logic [7:0] ADDR_TX_0   = 8'h00;
  localparam logic [7:0] ADDR_RX_0   = 8'h00;
  localparam logic [7:0] ADDR_CTRL   = 8'h10;
  localparam logic [7:0] ADDR_DIVIDE = 8'h14;
  localparam logic [7:0] ADDR_SS     = 8'h18;

  localparam int CTRL_CHAR_LEN_LSB = 0;
  localparam int CTRL_CHAR_LEN_MSB = 6;
  localparam int CTRL_GO_BIT       = 8;
  localparam int CTRL_RX_NEG_BIT   = 9;
  localparam int CTRL_TX_NEG_BIT   = 10;
  localparam int CTRL_LSB_BIT      = 11;
  localparam int CTRL_IE_BIT       = 12;
  localparam int CTRL_ASS_BIT      = 13;

  // MOSI changes on the falling edge and MISO is sampled on the rising edge;
  // slave select is driven automatically by the core for the character.
  function automatic logic [31:0] ctrl_word(input logic [6:0] char_len,
                                            input logic       lsb_first,
                                            input logic       ie);
    logic [31:0] w;
    w = '0;
    w[CTRL_CHAR_LEN_MSB:CTRL_CHAR_LEN_LSB] = char_len;
    w[CTRL_GO_BIT]     = 1'b1;
    w[CTRL_RX_NEG_BIT] = 1'b0;
    w[CTRL_TX_NEG_BIT] = 1'b1;
    w[CTRL_LSB_BIT]    = lsb_first;
    w[CTRL_IE_BIT]     = ie;
    w[CTRL_ASS_BIT]    = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/spi_xfer_fifo.sv
// spi_xfer_fifo: synchronous first-word-fall-through FIFO.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   push_i, wdata_i    : write side
//   pop_i, rdata_o     : read side; rdata_o is the head entry
//   empty_o, full_o    : occupancy flags
// A push and a pop in the same cycle are accepted on a full or an empty FIFO.
// When empty, the pushed word passes straight through to rdata_o, so a pop in
// that cycle consumes it without it ever being stored.
module spi_xfer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;
  logic             wr_en;
  logic             rd_en;

  assign empty_o = (count == '0);
  assign full_o  = (count == (AW+1)'(DEPTH));

  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && (!empty_o || push_i);
  // pass-through on empty: neither store nor advance
  assign wr_en   = do_push && !(empty_o && do_pop);
  assign rd_en   = do_pop && !empty_o;

  assign rdata_o = empty_o ? wdata_i : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/spi_xfer_seq.sv
// spi_xfer_seq: streams bytes through a register-mapped SPI core.
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   divider_i, ss_i, cfg_load_i      : DIVIDE/SS values and reprogram request
//   tx_valid_i/tx_ready_o/tx_data_i  : transmit byte stream in
//   rx_valid_o/rx_ready_i/rx_data_o  : receive byte stream out
//   addr_o, wdata_o, be_o, we_o, re_o: registered core register port
//   rdata_i                          : core read data, one cycle after re_o
//   intr_i                           : core end-of-character pulse
//   busy_o                           : FSM not idle or TX bytes pending
// Build option: SPI_XFER_IRQ_WAIT_EN waits for intr_i instead of polling CTRL.
//
// state      | meaning
// CFG_DIV    | DIVIDE write on the port
// CFG_SS     | SS write on the port
// IDLE       | waiting for a TX byte or a reconfiguration request
// LOAD       | TX_0 write of the popped byte on the port
// GO         | CTRL write starting the character
// POLL_RD    | CTRL read on the port
// POLL_CK    | CTRL read data available; GO clear means done
// WAIT       | waiting for intr_i (interrupt build only)
// RX_RD      | RX_0 read on the port
// RX_CAP     | RX_0 read data captured
// RX_PUSH    | pushing received byte; holds while RX FIFO is full
module spi_xfer_seq
  import spi_xfer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CHAR_LEN   = 8,
  parameter int LSB_FIRST  = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] divider_i,
  input  logic [7:0]  ss_i,
  input  logic        cfg_load_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [7:0]  tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [7:0]  rx_data_o,
  output logic [7:0]  addr_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  output logic        we_o,
  output logic        re_o,
  input  logic [31:0] rdata_i,
  input  logic        intr_i,
  output logic        busy_o
);

`ifdef SPI_XFER_IRQ_WAIT_EN
  localparam logic IRQ_IE = 1'b1;
`else
  localparam logic IRQ_IE = 1'b0;
`endif

  localparam logic [31:0] CTRL_WDATA = ctrl_word(7'(CHAR_LEN), (LSB_FIRST != 0), IRQ_IE);

  state_e      state_q, state_d;
  logic        cfg_pend_q;
  logic [7:0]  rx_byte_q;

  logic        tx_push, tx_pop, tx_empty, tx_full, tx_avail;
  logic [7:0]  tx_head;
  logic        rx_push, rx_pop, rx_empty, rx_full;

  logic        we_d, re_d;
  logic [7:0]  addr_d;
  logic [31:0] wdata_d;
  logic [3:0]  be_d;

  logic        unused_ok;
  assign unused_ok = ^{rdata_i[31:8], intr_i};

  assign tx_ready_o = !tx_full;
  assign tx_push    = tx_valid_i && tx_ready_o;
  // a byte arriving this cycle is already visible at the FIFO head
  assign tx_avail   = !tx_empty || tx_push;
  assign rx_valid_o = !rx_empty;
  assign rx_pop     = rx_valid_o && rx_ready_i;
  assign busy_o     = (state_q != ST_IDLE) || !tx_empty;

  spi_xfer_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (tx_push),
    .wdata_i (tx_data_i),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .empty_o (tx_empty),
    .full_o  (tx_full)
  );

  spi_xfer_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_push),
    .wdata_i (rx_byte_q),
    .pop_i   (rx_pop),
    .rdata_o (rx_data_o),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );

  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    unique case (state_q)
      // Out of reset CFG_DIV is held once so its write can be issued;
      // once we_o shows the DIVIDE write, move on.
      ST_CFG_DIV: if (we_o) state_d = ST_CFG_SS;
      ST_CFG_SS:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (cfg_pend_q || cfg_load_i) begin
          state_d = ST_CFG_DIV;
        end else if (tx_avail) begin
          state_d = ST_LOAD;
          tx_pop  = 1'b1;
        end
      end
      ST_LOAD: state_d = ST_GO;
`ifdef SPI_XFER_IRQ_WAIT_EN
      ST_GO:   state_d = ST_WAIT;
      ST_WAIT: if (intr_i) state_d = ST_RX_RD;
`else
      ST_GO:      state_d = ST_POLL_RD;
      ST_POLL_RD: state_d = ST_POLL_CK;
      ST_POLL_CK: state_d = rdata_i[CTRL_GO_BIT] ? ST_POLL_RD : ST_RX_RD;
`endif
      ST_RX_RD:  state_d = ST_RX_CAP;
      ST_RX_CAP: state_d = ST_RX_PUSH;
      ST_RX_PUSH: begin
        if (!rx_full) begin
          rx_push = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_CFG_DIV;
    endcase

    // Port outputs are registered, so the access belongs to the state being entered.
    we_d    = 1'b0;
    re_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    be_d    = '0;
    case (state_d)
      ST_CFG_DIV: begin
        if (!(state_q == ST_CFG_DIV && we_o)) begin
          we_d    = 1'b1;
          addr_d  = ADDR_DIVIDE;
          wdata_d = {16'b0, divider_i};
          be_d    = 4'b0011;
        end
      end
      ST_CFG_SS: begin
        we_d    = 1'b1;
        addr_d  = ADDR_SS;
        wdata_d = {24'b0, ss_i};
        be_d    = 4'b0001;
      end
      ST_LOAD: begin
        we_d    = 1'b1;
        addr_d  = ADDR_TX_0;
        wdata_d = {24'b0, tx_head};
        be_d    = 4'b0001;
      end
      ST_GO: begin
        we_d    = 1'b1;
        addr_d  = ADDR_CTRL;
        wdata_d = CTRL_WDATA;
        be_d    = 4'b0011;
      end
      ST_POLL_RD: begin
        re_d   = 1'b1;
        addr_d = ADDR_CTRL;
      end
      ST_RX_RD: begin
        re_d   = 1'b1;
        addr_d = ADDR_RX_0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_CFG_DIV;
      cfg_pend_q <= 1'b0;
      rx_byte_q  <= '0;
      we_o       <= 1'b0;
      re_o       <= 1'b0;
      addr_o     <= '0;
      wdata_o    <= '0;
      be_o       <= '0;
    end else begin
      state_q <= state_d;
      we_o    <= we_d;
      re_o    <= re_d;
      addr_o  <= addr_d;
      wdata_o <= wdata_d;
      be_o    <= be_d;
      if (state_d == ST_CFG_DIV && state_q != ST_CFG_DIV) begin
        cfg_pend_q <= 1'b0;
      end else if (cfg_load_i && state_q != ST_IDLE) begin
        cfg_pend_q <= 1'b1;
      end
      if (state_q == ST_RX_CAP) rx_byte_q <= rdata_i[7:0];
    end
  end

endmodule

// File: tb/tb_spi_xfer_seq.sv
module tb_spi_xfer_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] divider_i;
  logic [7:0]  ss_i;
  logic        cfg_load_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  tx_data_i;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [7:0]  rx_data_o;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic        we_o;
  logic        re_o;
  logic [31:0] rdata_i = '0;
  logic        intr_i = 1'b0;
  logic        busy_o;

`ifdef SPI_XFER_IRQ_WAIT_EN
  localparam logic [31:0] EXP_CTRL = 32'h0000_3508;
`else
  localparam logic [31:0] EXP_CTRL = 32'h0000_2508;
`endif

  spi_xfer_seq #(.FIFO_DEPTH(8), .CHAR_LEN(8), .LSB_FIRST(0)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .divider_i  (divider_i),
    .ss_i       (ss_i),
    .cfg_load_i (cfg_load_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .tx_data_i  (tx_data_i),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .rx_data_o  (rx_data_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .be_o       (be_o),
    .we_o       (we_o),
    .re_o       (re_o),
    .rdata_i    (rdata_i),
    .intr_i     (intr_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // SPI core model: MOSI looped back to MISO, never reset by rst_i.
  logic [31:0] ctrl_reg = '0;
  logic [7:0]  txr = '0;
  logic [7:0]  rxr = '0;
  int          shift_cnt = 0;
  always @(posedge clk_i) begin
    intr_i <= 1'b0;
    if (re_o) begin
      if (addr_o == 8'h10)      rdata_i <= ctrl_reg;
      else if (addr_o == 8'h00) rdata_i <= {24'b0, rxr};
      else                      rdata_i <= '0;
    end
    if (we_o && addr_o == 8'h00) txr <= wdata_o[7:0];
    if (we_o && addr_o == 8'h10 && wdata_o[8]) begin
      ctrl_reg  <= wdata_o;
      shift_cnt <= 4 + int'(txr % 3);
    end else if (shift_cnt != 0) begin
      shift_cnt <= shift_cnt - 1;
      if (shift_cnt == 1) begin
        ctrl_reg[8] <= 1'b0;
        rxr         <= txr;
        intr_i      <= 1'b1;
      end
    end
  end

  typedef struct {
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cyc;
  } acc_t;

  acc_t       log_q[$];
  logic [7:0] exp_q[$];
  int         both_cnt = 0;
  int         intr_cyc = -1;
  int         n_cmp = 0;
  int         n_mism = 0;

  always @(negedge clk_i) begin
    if (we_o || re_o) log_q.push_back('{we_o, re_o, addr_o, wdata_o, be_o, cyc});
    if (we_o && re_o) both_cnt++;
    if (intr_i) intr_cyc = cyc;
  end

  function automatic int count_acc(input logic we, input logic [7:0] addr);
    int c = 0;
    foreach (log_q[i]) if (log_q[i].we == we && log_q[i].re == !we && log_q[i].addr == addr) c++;
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    tx_valid_i = 1'b1;
    tx_data_i  = b;
    while (tx_ready_o !== 1'b1 && t < 500) begin @(negedge clk_i); t++; end
    if (tx_ready_o === 1'b1) begin
      exp_q.push_back(b);
      @(negedge clk_i);
    end else begin
      n_cmp++; n_mism++;
      $display("FAIL send_byte timeout: tx_ready_o=%b, required 1", tx_ready_o);
    end
    tx_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy_o !== 1'b0 && t < budget) begin @(negedge clk_i); t++; end
    if (busy_o !== 1'b0) begin
      n_cmp++; n_mism++;
      $display("FAIL wait_idle timeout: busy_o=%b, required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; divider_i = 16'd4; ss_i = 8'h01; cfg_load_i = 1'b0;
    tx_valid_i = 1'b0; tx_data_i = '0; rx_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if ({tx_ready_o, rx_valid_o, busy_o, we_o, re_o} !== 5'b10100) begin
      n_mism++;
      $display("FAIL reset flags: rdy/val/busy/we/re=%b, required 10100",
               {tx_ready_o, rx_valid_o, busy_o, we_o, re_o});
    end
    n_cmp++;
    if ({addr_o, wdata_o, be_o, rx_data_o} !== '0) begin
      n_mism++;
      $display("FAIL reset port: addr=%h wdata=%h be=%h rx_data=%h, required all 0",
               addr_o, wdata_o, be_o, rx_data_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({we_o, re_o, addr_o, wdata_o, be_o} !== {2'b10, 8'h14, 32'h4, 4'b0011}) begin
      n_mism++;
      $display("FAIL cfg divide: we=%b re=%b addr=%h wdata=%h be=%b, required we 1 addr 14 wdata 4 be 0011",
               we_o, re_o, addr_o, wdata_o, be_o);
    end
    n_cmp++;
    if (tx_ready_o !== 1'b1) begin
      n_mism++; $display("FAIL cfg tx_ready: got %b, required 1", tx_ready_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if ({we_o, re_o, addr_o, wdata_o, be_o} !== {2'b10, 8'h18, 32'h1, 4'b0001}) begin
      n_mism++;
      $display("FAIL cfg ss: we=%b re=%b addr=%h wdata=%h be=%b, required we 1 addr 18 wdata 1 be 0001",
               we_o, re_o, addr_o, wdata_o, be_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if ({busy_o, we_o, re_o} !== 3'b000) begin
      n_mism++; $display("FAIL idle after cfg: busy/we/re=%b, required 000", {busy_o, we_o, re_o});
    end
  endtask

  task automatic test_single();
    int t = 0;
    int nrd = 0;
    int ridx = -1;
    logic [7:0] e;
    log_q.delete();
    send_byte(8'hA5);
    n_cmp++;
    if ({we_o, addr_o, wdata_o, be_o} !== {1'b1, 8'h00, 32'hA5, 4'b0001}) begin
      n_mism++;
      $display("FAIL tx load latency: we=%b addr=%h wdata=%h be=%b, required we 1 addr 00 wdata a5 be 0001",
               we_o, addr_o, wdata_o, be_o);
    end
    rx_ready_i = 1'b1;
    while (rx_valid_o !== 1'b1 && t < 300) begin @(negedge clk_i); t++; end
    n_cmp++;
    if (rx_valid_o !== 1'b1) begin
      n_mism++; $display("FAIL single rx timeout: rx_valid_o=%b, required 1", rx_valid_o);
    end else begin
      e = exp_q.pop_front();
      if (rx_data_o !== e) begin
        n_mism++; $display("FAIL single rx data: got %h, required %h", rx_data_o, e);
      end
    end
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    n_cmp++;
    if (log_q.size() < 3 || log_q[1].we !== 1'b1 || log_q[1].addr !== 8'h10 ||
        log_q[1].wdata !== EXP_CTRL || log_q[1].be !== 4'b0011) begin
      n_mism++;
      $display("FAIL ctrl write: entries=%0d wdata=%h, required addr 10 wdata %h be 0011",
               log_q.size(), (log_q.size() > 1) ? log_q[1].wdata : 32'hx, EXP_CTRL);
    end
    foreach (log_q[i]) begin
      if (log_q[i].re && log_q[i].addr == 8'h10) nrd++;
      if (log_q[i].re && log_q[i].addr == 8'h00) ridx = i;
    end
    n_cmp++;
`ifdef SPI_XFER_IRQ_WAIT_EN
    if (nrd != 0) begin
      n_mism++; $display("FAIL ctrl reads: got %0d, required 0", nrd);
    end
    n_cmp++;
    if (ridx < 0 || log_q[ridx].cyc != intr_cyc + 1) begin
      n_mism++;
      $display("FAIL rx read after intr: rx read cycle %0d, required %0d",
               (ridx < 0) ? -1 : log_q[ridx].cyc, intr_cyc + 1);
    end
`else
    if (nrd < 1) begin
      n_mism++; $display("FAIL ctrl reads: got %0d, required at least 1", nrd);
    end
    n_cmp++;
    if (ridx != log_q.size() - 1 || ridx != 2 + nrd) begin
      n_mism++; $display("FAIL rx read position: index %0d, required %0d", ridx, 2 + nrd);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int t = 0;
    logic [7:0] e;
    log_q.delete();
    rx_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    wait_idle(2000);
    n_cmp++;
    if (count_acc(1'b1, 8'h10) != 8) begin
      n_mism++; $display("FAIL b2b go count: got %0d, required 8", count_acc(1'b1, 8'h10));
    end
    n_cmp++;
    if ({tx_ready_o, rx_valid_o} !== 2'b11) begin
      n_mism++; $display("FAIL b2b flags: tx_ready/rx_valid=%b, required 11", {tx_ready_o, rx_valid_o});
    end
    send_byte(8'h08);
    send_byte(8'h09);
    repeat (200) @(negedge clk_i);
    n_cmp++;
    if (count_acc(1'b1, 8'h10) != 9 || busy_o !== 1'b1) begin
      n_mism++;
      $display("FAIL rx full stall: go count %0d busy %b, required 9 and 1", count_acc(1'b1, 8'h10), busy_o);
    end
    rx_ready_i = 1'b1;
    while (got < 10 && t < 1000) begin
      if (rx_valid_o === 1'b1) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_data_o !== e) begin
          n_mism++; $display("FAIL b2b order: got %h, required %h", rx_data_o, e);
        end
        got++;
      end
      @(negedge clk_i);
      t++;
    end
    rx_ready_i = 1'b0;
    n_cmp++;
    if (got != 10) begin
      n_mism++; $display("FAIL b2b drain: got %0d bytes, required 10", got);
    end
  endtask

  task automatic test_cfg_load();
    int t = 0;
    int got = 0;
    int di = -1;
    int ri = -1;
    int ti = -1;
    int ntx = 0;
    logic [7:0] e;
    log_q.delete();
    send_byte(8'h3C);
    send_byte(8'hC3);
    while (!(we_o === 1'b1 && addr_o == 8'h10) && t < 200) begin @(negedge clk_i); t++; end
    @(negedge clk_i);
    cfg_load_i = 1'b1; divider_i = 16'd9; ss_i = 8'h02;
    @(negedge clk_i);
    cfg_load_i = 1'b0;
    wait_idle(1000);
    rx_ready_i = 1'b1;
    t = 0;
    while (got < 2 && t < 100) begin
      if (rx_valid_o === 1'b1) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_data_o !== e) begin
          n_mism++; $display("FAIL cfg_load rx: got %h, required %h", rx_data_o, e);
        end
        got++;
      end
      @(negedge clk_i);
      t++;
    end
    rx_ready_i = 1'b0;
    foreach (log_q[i]) begin
      if (di < 0 && log_q[i].we && log_q[i].addr == 8'h14) di = i;
      if (ri < 0 && log_q[i].re && log_q[i].addr == 8'h00) ri = i;
      if (log_q[i].we && log_q[i].addr == 8'h00) begin ntx++; if (ntx == 2) ti = i; end
    end
    n_cmp++;
    if (di < 0 || ri < 0 || log_q[di].cyc - log_q[ri].cyc != 4 || log_q[di].wdata !== 32'h9) begin
      n_mism++;
      $display("FAIL cfg_load divide: index %0d after rx read %0d, wdata %h, required 4 cycles after, wdata 9",
               di, ri, (di < 0) ? 32'hx : log_q[di].wdata);
    end
    n_cmp++;
    if (di < 0 || di + 1 >= log_q.size() || log_q[di+1].addr !== 8'h18 || log_q[di+1].wdata !== 32'h2 ||
        ti != di + 2 || log_q[ti].wdata !== 32'hC3) begin
      n_mism++;
      $display("FAIL cfg_load order: divide %0d second tx %0d, required ss then tx c3 next", di, ti);
    end
    n_cmp++;
    if (count_acc(1'b1, 8'h14) != 1) begin
      n_mism++; $display("FAIL cfg_load divide count: got %0d, required 1", count_acc(1'b1, 8'h14));
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    send_byte(8'h11);
    wait_idle(300);
    send_byte(8'h5A);
    send_byte(8'h66);
`ifdef SPI_XFER_IRQ_WAIT_EN
    while (!(we_o === 1'b1 && addr_o == 8'h10) && t < 200) begin @(negedge clk_i); t++; end
`else
    while (!(re_o === 1'b1 && addr_o == 8'h10) && t < 200) begin @(negedge clk_i); t++; end
`endif
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    log_q.delete();
    exp_q.delete();
    n_cmp++;
    if ({we_o, re_o, rx_valid_o, busy_o, tx_ready_o} !== 5'b00011) begin
      n_mism++;
      $display("FAIL mid reset: we/re/rx_valid/busy/tx_ready=%b, required 00011",
               {we_o, re_o, rx_valid_o, busy_o, tx_ready_o});
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({we_o, addr_o, wdata_o} !== {1'b1, 8'h14, 32'h9}) begin
      n_mism++;
      $display("FAIL restart divide: we=%b addr=%h wdata=%h, required we 1 addr 14 wdata 9", we_o, addr_o, wdata_o);
    end
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({busy_o, rx_valid_o} !== 2'b00) begin
      n_mism++; $display("FAIL fifos flushed: busy/rx_valid=%b, required 00", {busy_o, rx_valid_o});
    end
    repeat (40) @(negedge clk_i);
    n_cmp++;
    if (rx_valid_o !== 1'b0 || log_q.size() != 2) begin
      n_mism++;
      $display("FAIL after reset quiet: rx_valid %b accesses %0d, required 0 and 2", rx_valid_o, log_q.size());
    end
  endtask

  task automatic test_port_rules();
    n_cmp++;
    if (both_cnt != 0) begin
      n_mism++; $display("FAIL we_re exclusive: %0d cycles with both, required 0", both_cnt);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mism++; $display("FAIL scoreboard leftover: %0d bytes, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cfg_load();
    test_reset_mid();
    test_port_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule

// File: doc/spi_xfer_seq.md
# spi_xfer_seq

Byte-stream sequencer directly upstream of the SPI core. It accepts transmit bytes on a valid/ready stream and drives the core's register write/read port: divider and slave-select setup, TX load, GO, completion wait, RX readback. Received bytes are returned on a second valid/ready stream. It turns the register-mapped SPI core into a streaming full-duplex byte pipe for the rest of the design.

## Interface
- FIFO_DEPTH, 8: entries in each of the TX and RX FIFOs; must be a power of 2 and at least 2.
- CHAR_LEN, 8: bits per SPI character, 1..8; written to CTRL[6:0].
- LSB_FIRST, 0: value driven into CTRL[11].

- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- divider_i  in  16  SCLK divider value, written to DIVIDE
- ss_i  in  8  slave-select mask, written to SS
- cfg_load_i  in  1  one-cycle pulse that requests reprogramming of DIVIDE and SS
- tx_valid_i / tx_ready_o / tx_data_i  in/out/in  1/1/8  transmit byte stream
- rx_valid_o / rx_ready_i / rx_data_o  out/in/out  1/1/8  receive byte stream
- addr_o  out  8  core register byte address: TX_0/RX_0=0x00, CTRL=0x10, DIVIDE=0x14, SS=0x18
- wdata_o  out  32  core write data
- be_o  out  4  core byte enables
- we_o, re_o  out  1  core write and read strobes, never asserted together
- rdata_i  in  32  core read data, registered in the core; valid the cycle after the address is presented
- intr_i  in  1  core end-of-character interrupt pulse
- busy_o  out  1  high when the FSM is outside IDLE or the TX FIFO is non-empty

## Operation
- States: CFG_DIV, CFG_SS, IDLE, LOAD, GO, POLL_RD, POLL_CK, RX_RD, RX_CAP, RX_PUSH.
- After reset the FSM enters CFG_DIV.
  - CFG_DIV: write DIVIDE with be=0011 and wdata={16'b0,divider_i}.
  - CFG_SS: write SS with be=0001. Then go to IDLE.
- IDLE:
  - A pending cfg_load has priority and goes to CFG_DIV.
  - Otherwise, if the TX FIFO is non-empty, go to LOAD.
- cfg_load_i outside IDLE sets a sticky pending flag. The flag clears on entry to CFG_DIV.
- LOAD: pop the TX FIFO and write TX_0 with be=0001 and wdata={24'b0,byte}.
- GO: write CTRL with be=0011 and wdata[13:0]={ASS=1, IE, LSB_FIRST, TX_NEGEDGE=1, RX_NEGEDGE=0, GO=1, 1'b0, CHAR_LEN[6:0]}. IE is 0 unless the macro is defined.
- POLL_RD: present CTRL with re_o=1.
- POLL_CK: if rdata_i[8]==0, go to RX_RD; otherwise go back to POLL_RD.
- RX_RD: present RX_0 with re_o=1.
- RX_CAP: latch rdata_i[7:0].
- RX_PUSH:
  - If the RX FIFO has space, push the byte and go to IDLE.
  - If the RX FIFO is full, stay in RX_PUSH. No TX byte is popped and no new GO is written while stalled.
- FIFOs are first-word-fall-through.
  - tx_ready_o = !tx_full.
  - rx_valid_o = !rx_empty; rx_data_o is the head entry.
  - Simultaneous push and pop on a full or empty FIFO are both legal. Count is unchanged, data ordering is preserved, and pointers wrap modulo FIFO_DEPTH.
- Bytes in equal bytes out, in order. One RX byte is produced per TX byte.

## Timing
- Reset values:
  - tx_ready_o=1, rx_valid_o=0, busy_o=1 (in CFG_DIV).
  - we_o=re_o=0, addr_o=0, wdata_o=0, be_o=0, rx_data_o=0.
- All core-port outputs are registered and are valid for exactly one cycle per access.
- Configuration takes 2 cycles after reset deassertion; tx_ready_o is already high during it.
- Per-character overhead, excluding SPI shift time: LOAD 1 + GO 1 + at least one 2-cycle poll + RX 3 = 7 cycles minimum.
- A TX byte accepted in IDLE with an empty FIFO gives we_o for TX_0 on the following cycle.
- rst_i asserted mid-transfer returns to CFG_DIV, empties both FIFOs, and drops all strobes next cycle. A core still shifting is not aborted; its result is discarded.

## Configuration
- SPI_XFER_IRQ_WAIT_EN
  - Defined: CTRL IE=1. POLL_RD/POLL_CK are replaced by a single WAIT state that advances to RX_RD on intr_i=1, with no CTRL reads. An intr_i pulse in any other state is ignored.
  - Undefined: polling as described above; intr_i is unused.

## Structure
- spi_xfer_pkg holds:
  - the state enum;
  - register offset constants (TX_0, RX_0, CTRL, DIVIDE, SS);
  - CTRL bit positions (GO=8, RX_NEGEDGE=9, TX_NEGEDGE=10, LSB=11, IE=12, ASS=13, CHAR_LEN=6:0).
- Sub-module spi_xfer_fifo: synchronous FWFT FIFO parameterised by width and depth, instantiated for TX and RX.

## Test plan
- Reset, then idle: DIVIDE write with wdata=0x0004 when divider_i=4, then SS write with wdata=0x01 when ss_i=1, then IDLE with busy_o=0.
- Push 0xA5 with a core model looping MOSI to MISO: the sequence is TX_0 write 0xA5, CTRL write 0x2508, polling, RX_0 read, then rx_data_o=0xA5.
- Push 8 bytes 0x00..0x07 back-to-back with rx_ready_i=0: after 8 transfers tx_ready_o stays 1, there is no 9th GO, and rx_valid_o=1. Then release rx_ready_i: 0x00..0x07 come out in order.
- Pulse cfg_load_i during POLL: no DIVIDE write until the current byte has been pushed, then CFG_DIV/CFG_SS, then the next byte.
- Assert rst_i in POLL_CK: strobes are 0 next cycle, rx_valid_o=0, and configuration restarts.
- With SPI_XFER_IRQ_WAIT_EN defined: CTRL wdata=0x3508, there are zero CTRL reads, and RX_0 is read the cycle after intr_i.
